// File: rtl/dof_stage_p_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dof_pkg
//  Description : Shared encodings for the decode/operand-fetch stage:
//                MD / BS encodings, FS width, instruction field positions,
//                opcode map and the decoded control-word type.
//  Revision    : 1.0  initial release
// ============================================================================
package dof_pkg;

  // Result-source select carried to EX/WB
  localparam logic [1:0] MD_ALU  = 2'b00;
  localparam logic [1:0] MD_LOAD = 2'b01;
  localparam logic [1:0] MD_SLT  = 2'b10;

  // Branch select
  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JMPR = 2'b10;
  localparam logic [1:0] BS_JMPL = 2'b11;

  // Function select
  localparam int unsigned FS_W = 5;
  localparam logic [FS_W-1:0] FS_MOVA = 5'b00000;
  localparam logic [FS_W-1:0] FS_ADD  = 5'b00010;
  localparam logic [FS_W-1:0] FS_SUB  = 5'b00101;
  localparam logic [FS_W-1:0] FS_AND  = 5'b01000;

  // Instruction field positions
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 25;
  localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;
  localparam int unsigned DA_LSB = 20;
  localparam int unsigned AA_LSB = 15;
  localparam int unsigned BA_LSB = 10;
  localparam int unsigned SH_LSB = 0;
  localparam int unsigned SH_W   = 5;

  // Opcode map
  localparam logic [OP_W-1:0] OP_NOP  = 7'h00;
  localparam logic [OP_W-1:0] OP_ST   = 7'h01;
  localparam logic [OP_W-1:0] OP_ADD  = 7'h02;
  localparam logic [OP_W-1:0] OP_SUB  = 7'h05;
  localparam logic [OP_W-1:0] OP_JML  = 7'h07;
  localparam logic [OP_W-1:0] OP_LD   = 7'h21;
  localparam logic [OP_W-1:0] OP_ADDI = 7'h22;
  localparam logic [OP_W-1:0] OP_SLT  = 7'h25;
  localparam logic [OP_W-1:0] OP_ANDI = 7'h28;
  localparam logic [OP_W-1:0] OP_JMP  = 7'h44;
  localparam logic [OP_W-1:0] OP_BZ   = 7'h60;
  localparam logic [OP_W-1:0] OP_BNZ  = 7'h61;

  typedef struct packed {
    logic            rw;
    logic [1:0]      md;
    logic [1:0]      bs;
    logic            ps;
    logic            mw;
    logic [FS_W-1:0] fs;
    logic            ma;
    logic            mb;
    logic            cs;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/dof_stage_p_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decoder
//  Description : Maps the 7-bit opcode onto the control word
//                (RW, MD, BS, PS, MW, FS, MA, MB, CS). Unknown opcodes
//                decode to an all-zero NOP so they never write anything.
//  Ports       : opcode (in)  - ir[31:25]
//                ctrl   (out) - decoded control word
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_decoder
  import dof_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_ADD:  begin ctrl.rw = 1'b1; ctrl.fs = FS_ADD; end
      OP_SUB:  begin ctrl.rw = 1'b1; ctrl.fs = FS_SUB; end
      OP_ADDI: begin ctrl.rw = 1'b1; ctrl.fs = FS_ADD; ctrl.mb = 1'b1; ctrl.cs = 1'b1; end
      OP_ANDI: begin ctrl.rw = 1'b1; ctrl.fs = FS_AND; ctrl.mb = 1'b1; end
      OP_LD:   begin ctrl.rw = 1'b1; ctrl.md = MD_LOAD; ctrl.fs = FS_MOVA; end
      OP_ST:   begin ctrl.mw = 1'b1; ctrl.fs = FS_MOVA; end
      OP_SLT:  begin ctrl.rw = 1'b1; ctrl.md = MD_SLT; ctrl.fs = FS_SUB; end
      OP_BZ:   begin ctrl.bs = BS_COND; ctrl.mb = 1'b1; ctrl.cs = 1'b1; end
      OP_BNZ:  begin ctrl.bs = BS_COND; ctrl.ps = 1'b1; ctrl.mb = 1'b1; ctrl.cs = 1'b1; end
      OP_JMP:  begin ctrl.bs = BS_JMPR; end
      OP_JML:  begin
        ctrl.rw = 1'b1; ctrl.bs = BS_JMPL; ctrl.fs = FS_ADD;
        ctrl.ma = 1'b1; ctrl.mb = 1'b1; ctrl.cs = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dof_stage_p.sv
`default_nettype none
// ============================================================================
//  Module      : dof_stage_p
//  Description : Decode/operand-fetch stage. Decodes ir, drives register
//                file read addresses, builds bus A/B with constant unit and
//                EX/WB forwarding, detects load-use hazards and holds the
//                result in the DOF/EX pipeline register.
//  Ports       : clk, rst (async, active-low)
//                in_valid/in_ready, pc_in, ir        - from IF
//                aa, ba / a_rf, b_rf                 - register file read
//                ex_*, wb_*                          - forwarding sources
//                ex_stall, flush                     - pipeline control
//                hazard                              - load-use stall
//                out_*                               - DOF/EX register
//  Revision    : 1.0  initial release
// ============================================================================
module dof_stage_p
  import dof_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 16,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned IM_W   = 15,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [31:0]       ir,
  output logic [RA_W-1:0]   aa,
  output logic [RA_W-1:0]   ba,
  input  logic [DATA_W-1:0] a_rf,
  input  logic [DATA_W-1:0] b_rf,
  input  logic              ex_rw,
  input  logic [1:0]        ex_md,
  input  logic [RA_W-1:0]   ex_da,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              wb_rw,
  input  logic [RA_W-1:0]   wb_da,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              hazard,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_bus_a,
  output logic [DATA_W-1:0] out_bus_b,
  output logic [RA_W-1:0]   out_da,
  output logic [SH_W-1:0]   out_sh,
  output logic [FS_W-1:0]   out_fs,
  output logic              out_rw,
  output logic              out_ps,
  output logic              out_mw,
  output logic [1:0]        out_md,
  output logic [1:0]        out_bs
);

  ctrl_t             w_ctrl;
  logic [RA_W-1:0]   w_da;
  logic [IM_W-1:0]   w_imm;
  logic [DATA_W-1:0] w_const;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_bus_a;
  logic [DATA_W-1:0] w_bus_b;
  logic              w_ex_load;

  instruction_decoder u_dec (
    .opcode (ir[OP_MSB:OP_LSB]),
    .ctrl   (w_ctrl)
  );

  assign w_da  = ir[DA_LSB +: RA_W];
  assign aa    = ir[AA_LSB +: RA_W];
  assign ba    = ir[BA_LSB +: RA_W];
  assign w_imm = ir[IM_W-1:0];

  // Constant unit
  assign w_const = w_ctrl.cs ? {{(DATA_W-IM_W){w_imm[IM_W-1]}}, w_imm}
                             : {{(DATA_W-IM_W){1'b0}}, w_imm};

  assign w_ex_load = ex_rw && (ex_md == MD_LOAD);

  generate
    if (FWD_EN) begin : g_fwd
      // EX beats WB; R0 is hard-wired and never forwarded. A load in EX has
      // no data yet, so it is skipped here and covered by the hazard stall.
      always_comb begin
        w_op_a = a_rf;
        if (aa != '0) begin
          if (ex_rw && !w_ex_load && ex_da == aa) w_op_a = ex_result;
          else if (wb_rw && wb_da == aa)          w_op_a = wb_data;
        end
      end
      always_comb begin
        w_op_b = b_rf;
        if (ba != '0) begin
          if (ex_rw && !w_ex_load && ex_da == ba) w_op_b = ex_result;
          else if (wb_rw && wb_da == ba)          w_op_b = wb_data;
        end
      end
    end else begin : g_rf
      assign w_op_a = a_rf;
      assign w_op_b = b_rf;
    end
  endgenerate

  assign w_bus_a = w_ctrl.ma ? DATA_W'(pc_in) : w_op_a;
  assign w_bus_b = w_ctrl.mb ? w_const        : w_op_b;

  // Only sources actually routed to a bus can cause a load-use stall
  assign hazard = in_valid && w_ex_load && (ex_da != '0) &&
                  ((!w_ctrl.ma && ex_da == aa) || (!w_ctrl.mb && ex_da == ba));

  assign in_ready = !hazard && !ex_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_bus_a <= '0;
      out_bus_b <= '0;
      out_da    <= '0;
      out_sh    <= '0;
      out_fs    <= '0;
      out_rw    <= 1'b0;
      out_ps    <= 1'b0;
      out_mw    <= 1'b0;
      out_md    <= '0;
      out_bs    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_rw    <= 1'b0;
      out_mw    <= 1'b0;
    end else if (ex_stall) begin
      // hold
    end else if (hazard || !in_valid) begin
      out_valid <= 1'b0;
      out_rw    <= 1'b0;
      out_mw    <= 1'b0;
      out_ps    <= 1'b0;
      out_bs    <= '0;
    end else begin
      out_valid <= 1'b1;
      out_pc    <= pc_in;
      out_bus_a <= w_bus_a;
      out_bus_b <= w_bus_b;
      out_da    <= w_da;
      out_sh    <= ir[SH_LSB +: SH_W];
      out_fs    <= w_ctrl.fs;
      out_rw    <= w_ctrl.rw;
      out_ps    <= w_ctrl.ps;
      out_mw    <= w_ctrl.mw;
      out_md    <= w_ctrl.md;
      out_bs    <= w_ctrl.bs;
    end
  end

endmodule
`default_nettype wire

// File: doc/dof_stage_p.md
# dof_stage_p

Parametrised decode/operand-fetch pipeline stage for the RISC pipeline, sitting between the IF latch and the EX stage. It decodes the instruction word and drives register-file read addresses. It builds the A/B operand buses with a width-generic constant unit and EX/WB forwarding, detects load-use hazards, and holds the result in an internal DOF/EX pipeline register with valid/stall/flush control.

## Interface
- DATA_W, 32, operand/bus width
- PC_W, 16, program-counter width (PC_W ≤ DATA_W)
- RA_W, 5, register address width
- IM_W, 15, immediate field width, taken from ir[IM_W-1:0]
- FWD_EN, 1, 1 = EX/WB forwarding enabled; 0 = register-file data only

- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous and active-low
- in_valid  in  1  pc_in/ir hold a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- pc_in  in  PC_W  incremented PC from IF
- ir  in  32  instruction; opcode ir[31:25], DA ir[24:20], AA ir[19:15], BA ir[14:10], SH ir[4:0]
- aa, ba  out  RA_W  register-file read addresses, combinational from ir
- a_rf, b_rf  in  DATA_W  register-file read data for aa/ba, same cycle
- ex_rw, ex_md, ex_da, ex_result  in  1/2/RA_W/DATA_W  EX-stage write-back info and ALU result
- wb_rw, wb_da, wb_data  in  1/RA_W/DATA_W  WB-stage write port
- ex_stall  in  1  EX cannot accept; hold the output register
- flush  in  1  kill the instruction entering the output register
- hazard  out  1  load-use stall asserted this cycle
- out_valid  out  1  output register holds a live instruction
- out_pc  out  PC_W; out_bus_a, out_bus_b  out  DATA_W
- out_da, out_sh, out_fs  out  RA_W/5/5; out_rw, out_ps, out_mw  out  1; out_md, out_bs  out  2

## Operation
- The decoder produces RW, MD, BS, PS, MW, FS, MA, MB and CS from ir.
- Constant unit: CS=1 sign-extends ir[IM_W-1:0] to DATA_W. CS=0 zero-extends it.
- Operand select, raw value:
  - op_a = a_rf, or WB/EX-forwarded value. op_b likewise.
  - Forwarding condition (FWD_EN=1): source address ≠ 0, and match on EX (ex_rw & ex_da==src), else on WB (wb_rw & wb_da==src).
  - EX has priority over WB. Register 0 is never forwarded.
  - The EX path is not used when ex_md==2'b01 (load); that case is a hazard.
- Bus A: MA=1 gives zero-extended pc_in, otherwise op_a.
- Bus B: MB=1 gives the constant, otherwise op_b.
- A source is "used" when its mux selects the register (MA=0 / MB=0).
- hazard = in_valid & ex_rw & ex_md==2'b01 & ex_da≠0 & ex_da matches a used source.
- in_ready = ~hazard & ~ex_stall.
- Output register update (priority order):
  1. flush: out_valid, out_rw and out_mw are cleared. Other fields are don't-care.
  2. ex_stall: all outputs hold.
  3. hazard, or ~in_valid: a bubble is loaded. out_valid=0, out_rw=0, out_mw=0, out_ps=0, out_bs=0.
  4. otherwise: decoded fields, buses and pc_in are loaded, and out_valid=1.
- A bubble never writes a register or memory. Downstream relies on out_rw/out_mw being 0 whenever out_valid=0.

## Timing
- Reset (rst low, asynchronous): every out_* is 0, including out_valid. hazard and in_ready are combinational and follow their inputs.
- Latency: instruction accepted at edge n appears on out_* after edge n (one cycle).
- aa, ba, hazard and in_ready are combinational from ir and the EX/WB inputs. There is no registered path to the register file.
- Load-use costs exactly one bubble. Next cycle the load has moved to WB, and the WB forwarding path supplies the value.
- Simultaneous events:
  - flush and ex_stall in the same cycle: flush wins.
  - flush and hazard in the same cycle: flush wins, and in_ready stays 0.
- Reset asserted mid-stall clears the output register immediately. There is no pending state.

## Structure
- Package dof_pkg holds:
  - MD encodings (MD_ALU=2'b00, MD_LOAD=2'b01, MD_SLT=2'b10)
  - BS encodings
  - FS width constant
  - the opcode field position constants
- Sub-module: the existing InstructionDecoder, reused unchanged as the sole child.
- The constant unit, forwarding muxes, hazard logic and output register stay inline.

## Test plan
- ADDI R3,R1,#-5 (CS=1, MB=1), R1=10, no hazards -> one cycle later out_valid=1, out_bus_a=10, out_bus_b=0xFFFFFFFB, out_da=3.
- ADD R4,R1,R2 with ex_rw=1, ex_da=1, ex_result=7, and wb_rw=1, wb_da=1, wb_data=9 -> out_bus_a=7 (EX priority). Repeat with FWD_EN=0 -> out_bus_a=a_rf.
- ex_md=01, ex_da=2, ex_rw=1, ir uses R2 as B -> hazard=1 and in_ready=0 for one cycle, then a bubble (out_valid=0, out_rw=0). Next cycle with wb_da=2, wb_data=0x55 -> out_bus_b=0x55.
- Instruction with MA=1, pc_in=0x1234, DATA_W=32 -> out_bus_a=0x00001234. Same instruction with ex_da=AA as a load -> no hazard, since the A source is unused.
- ex_stall held 3 cycles with new ir changing -> out_* constant, and in_ready=0 throughout. flush asserted during the stall -> out_valid=0 next edge.
- rst low asynchronously mid-stream with out_valid=1 -> all out_* = 0 before the next clk edge. Source register R0 with ex_da=0 -> no forwarding and no hazard.
